// File: rtl/cb_pkg.sv
// Shared definitions for the control-bounded ADC encoder and filter.
// Control vectors use bit i = decision of stage i on both sides.
package cb_pkg;

    localparam int          CB_STATE_W       = 24;
    localparam int unsigned CB_KAPPA_DEFAULT = 32768;

    typedef logic signed [CB_STATE_W-1:0] cb_state_t;

    function automatic logic signed [63:0] cb_sat(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        r  = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/cbadc_modulator_if.sv
// Sample-in / control-vector-out bundle of the modulator.
interface cbadc_modulator_if #(
    parameter int N    = 3,
    parameter int IN_W = 16
);
    logic                   clr;
    logic signed [IN_W-1:0] u;
    logic                   u_valid;
    logic [N-1:0]           out;
    logic                   out_valid;
    logic [N-1:0]           ovf;

    modport master (
        output clr, u, u_valid,
        input  out, out_valid, ovf
    );

    modport slave (
        input  clr, u, u_valid,
        output out, out_valid, ovf
    );
endinterface

// File: rtl/cbadc_integrator.sv
// One integrator stage: x <= sat(x + in + f), f = -/+KAPPA from sign of x.
module cbadc_integrator
    import cb_pkg::*;
#(
    parameter int          STATE_W = 24,
    parameter int unsigned KAPPA   = CB_KAPPA_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic                      i_clr,
    input  logic signed [STATE_W-1:0] i_in,
    output logic signed [STATE_W-1:0] o_x,
    output logic                      o_s,
    output logic                      o_ovf
);
    localparam logic signed [STATE_W+1:0] L_KAP = (STATE_W+2)'(KAPPA);

    logic signed [STATE_W-1:0] r_x;
    logic                      r_ovf;
    logic                      w_s;
    logic signed [STATE_W+1:0] w_f;
    logic signed [STATE_W+1:0] w_sum;
    logic signed [63:0]        w_wide;
    logic signed [63:0]        w_sat;
    logic                      w_hit;

    assign w_s    = ~r_x[STATE_W-1];
    assign w_f    = w_s ? -L_KAP : L_KAP;
    assign w_sum  = (STATE_W+2)'(r_x) + (STATE_W+2)'(i_in) + w_f;
    assign w_wide = 64'(w_sum);
    assign w_sat  = cb_sat(w_wide, STATE_W);
    assign w_hit  = (w_sat != w_wide);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_x   <= '0;
            r_ovf <= 1'b0;
        end else if (i_en) begin
            r_x   <= w_sat[STATE_W-1:0];
            r_ovf <= r_ovf | w_hit;
        end
    end

    assign o_x   = r_x;
    assign o_s   = w_s;
    assign o_ovf = r_ovf;
endmodule

// File: rtl/cbadc_modulator.sv
// N-stage chain-of-integrators control-bounded ADC encoder.
module cbadc_modulator
    import cb_pkg::*;
#(
    parameter int          N       = 3,
    parameter int          IN_W    = 16,
    parameter int          STATE_W = 24,
    parameter int          BETA_SH = 0,
    parameter int unsigned KAPPA   = CB_KAPPA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    cbadc_modulator_if.slave  bus
);
    logic signed [STATE_W-1:0] w_x [N];
    logic [N-1:0]              w_s;
    logic [N-1:0]              w_ovf;
    logic                      w_step;
    logic [N-1:0]              r_out;
    logic                      r_out_valid;

    // clr wins over u_valid; the coincident sample is dropped
    assign w_step = bus.u_valid & ~bus.clr;

    for (genvar g = 0; g < N; g++) begin : g_st
        logic signed [STATE_W-1:0] w_in;
        if (g == 0) begin : g_first
            assign w_in = STATE_W'(bus.u);
        end else begin : g_chain
            assign w_in = w_x[g-1] >>> BETA_SH;
        end
        cbadc_integrator #(
            .STATE_W (STATE_W),
            .KAPPA   (KAPPA)
        ) u_int (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_step),
            .i_clr (bus.clr),
            .i_in  (w_in),
            .o_x   (w_x[g]),
            .o_s   (w_s[g]),
            .o_ovf (w_ovf[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.clr) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.u_valid) begin
            r_out       <= w_s;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.ovf       = w_ovf;
endmodule

// File: tb/tb_cbadc_modulator.sv
// Scoreboard bench for cbadc_modulator: default build plus a small
// saturating build (STATE_W=18, KAPPA=0).
module tb_cbadc_modulator;
    import cb_pkg::*;

    typedef struct {
        logic [2:0] out;
        logic [2:0] ovf;
        longint     x0;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    // model state: [0] = default build, [1] = saturating build
    longint     mx [2][3];
    logic [2:0] mov [2];

    cbadc_modulator_if #(.N(3), .IN_W(16)) bus_m ();
    cbadc_modulator_if #(.N(3), .IN_W(16)) bus_s ();

    cbadc_modulator #(
        .N(3), .IN_W(16), .STATE_W(24), .BETA_SH(0), .KAPPA(32768)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    cbadc_modulator #(
        .N(3), .IN_W(16), .STATE_W(18), .BETA_SH(0), .KAPPA(0)
    ) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic void model_clear(input int d);
        for (int i = 0; i < 3; i++) mx[d][i] = 0;
        mov[d] = 3'b000;
    endfunction

    // Forward-Euler step on unbounded integers, then clamp to the state range.
    function automatic logic [2:0] model_step(
        input int d, input longint uin, input int w, input longint k
    );
        logic [2:0] s;
        longint     nx [3];
        longint     lim;
        longint     t;
        lim = longint'(1) << (w - 1);
        for (int i = 0; i < 3; i++) s[i] = (mx[d][i] >= 0);
        for (int i = 0; i < 3; i++) begin
            t = mx[d][i] + (s[i] ? -k : k);
            t = t + ((i == 0) ? uin : mx[d][i-1]);
            if (t > lim - 1) begin
                t = lim - 1;
                mov[d][i] = 1'b1;
            end else if (t < -lim) begin
                t = -lim;
                mov[d][i] = 1'b1;
            end
            nx[i] = t;
        end
        for (int i = 0; i < 3; i++) mx[d][i] = nx[i];
        return s;
    endfunction

    task automatic cyc_m(input logic v, input logic signed [15:0] uu, input logic c);
        exp_t e;
        bus_m.u_valid = v;
        bus_m.u       = uu;
        bus_m.clr     = c;
        if (c) begin
            model_clear(0);
        end else if (v) begin
            e.out = model_step(0, longint'(uu), 24, 32768);
            e.ovf = mov[0];
            e.x0  = mx[0][0];
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        bus_m.u_valid = 1'b0;
        bus_m.clr     = 1'b0;
    endtask

    task automatic cyc_s(input logic signed [15:0] uu);
        exp_t e;
        bus_s.u_valid = 1'b1;
        bus_s.u       = uu;
        e.out = model_step(1, longint'(uu), 18, 0);
        e.ovf = mov[1];
        e.x0  = mx[1][0];
        q1.push_back(e);
        @(posedge clk);
        #1;
        bus_s.u_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && bus_m.out_valid) begin
            if (q0.size() == 0) begin
                chk("m_spurious_valid", 1, 0);
            end else begin
                e0 = q0.pop_front();
                chk("m_out", longint'(bus_m.out), longint'(e0.out));
                chk("m_ovf", longint'(bus_m.ovf), longint'(e0.ovf));
                chk("m_x0", longint'(dut.g_st[0].u_int.r_x), e0.x0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && bus_s.out_valid) begin
            if (q1.size() == 0) begin
                chk("s_spurious_valid", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("s_out", longint'(bus_s.out), longint'(e1.out));
                chk("s_ovf", longint'(bus_s.ovf), longint'(e1.ovf));
                chk("s_x0", longint'(dut_s.g_st[0].u_int.r_x), e1.x0);
            end
        end
    end

    initial begin
        logic signed [15:0] ru;
        checks = 0;
        errors = 0;
        model_clear(0);
        model_clear(1);
        bus_m.clr = 1'b0; bus_m.u = '0; bus_m.u_valid = 1'b0;
        bus_s.clr = 1'b0; bus_s.u = '0; bus_s.u_valid = 1'b0;

        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out", longint'(bus_m.out), 0);
        chk("rst_valid", longint'(bus_m.out_valid), 0);
        chk("rst_ovf", longint'(bus_m.ovf), 0);
        chk("rst_x0", longint'(dut.g_st[0].u_int.r_x), 0);
        chk("rst_x1", longint'(dut.g_st[1].u_int.r_x), 0);
        chk("rst_x2", longint'(dut.g_st[2].u_int.r_x), 0);

        // zero input, then a 3-cycle gap after the first step
        cyc_m(1'b1, 16'sd0, 1'b0);
        chk("zero_s1", longint'(bus_m.out), 3'b111);
        for (int i = 0; i < 3; i++) begin
            cyc_m(1'b0, 16'sd0, 1'b0);
            chk("gap_valid", longint'(bus_m.out_valid), 0);
            chk("gap_hold", longint'(bus_m.out), 3'b111);
        end
        cyc_m(1'b1, 16'sd0, 1'b0);
        chk("zero_s2", longint'(bus_m.out), 3'b000);
        cyc_m(1'b1, 16'sd0, 1'b0);
        chk("zero_s3", longint'(bus_m.out), 3'b001);

        // random sine-range samples with random gaps
        for (int n = 0; n < 300; n++) begin
            ru = 16'($signed($urandom_range(32767, 0)) - 16384);
            cyc_m(1'($urandom_range(3, 0) != 0), ru, 1'b0);
        end

        // clr together with u_valid: sample dropped, all state cleared
        cyc_m(1'b1, 16'sd1234, 1'b1);
        chk("clr_valid", longint'(bus_m.out_valid), 0);
        chk("clr_out", longint'(bus_m.out), 0);
        chk("clr_ovf", longint'(bus_m.ovf), 0);
        chk("clr_x0", longint'(dut.g_st[0].u_int.r_x), 0);
        chk("clr_x2", longint'(dut.g_st[2].u_int.r_x), 0);
        cyc_m(1'b1, 16'sd5000, 1'b0);
        chk("clr_next", longint'(bus_m.out), 3'b111);

        for (int n = 0; n < 100; n++) begin
            ru = 16'($urandom);
            cyc_m(1'b1, ru, 1'b0);
        end

        // saturating build: x0 ramps by 32767 per step until the clamp
        for (int n = 0; n < 15; n++) cyc_s(16'sd32767);
        @(negedge clk);
        chk("sat_x0", longint'(dut_s.g_st[0].u_int.r_x), 131071);
        chk("sat_ovf0", longint'(bus_s.ovf[0]), 1);

        // asynchronous reset in mid-run
        for (int n = 0; n < 20; n++) begin
            ru = 16'($urandom);
            cyc_m(1'b1, ru, 1'b0);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out", longint'(bus_m.out), 0);
        chk("arst_valid", longint'(bus_m.out_valid), 0);
        chk("arst_ovf_s", longint'(bus_s.ovf), 0);
        chk("arst_x1", longint'(dut.g_st[1].u_int.r_x), 0);
        model_clear(0);
        model_clear(1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 30; n++) begin
            ru = 16'($signed($urandom_range(32767, 0)) - 16384);
            cyc_m(1'b1, ru, 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("q0_drained", longint'(q0.size()), 0);
        chk("q1_drained", longint'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cbadc_modulator.md
# cbadc_modulator

Synthesizable digital emulation of an N-stage chain-of-integrators control-bounded ADC. It is the encoder side of the control-bounded filter: it turns a fixed-point input sample stream into N-bit control-signal vectors. Those vectors are in exactly the format consumed by `Batch_top.in`. It closes self-checking loops in simulation and FPGA bring-up without file-based stimulus, and feeds the filter directly (`out` → `Batch_top.in`).

## Interface
- `N`, 3, number of integrator stages and control bits
- `IN_W`, 16, input sample width, signed two's complement
- `STATE_W`, 24, integrator state width, signed
- `BETA_SH`, 0, inter-stage gain = 2^-BETA_SH (arithmetic right shift)
- `KAPPA`, 32768, control feedback magnitude, unsigned, < 2^(STATE_W-1)

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `clr`  in  1  synchronous clear of all state
- `u`  in  IN_W  input sample, signed
- `u_valid`  in  1  advance modulator one step using `u`
- `out`  out  N  control vector; `out[i]` = decision of stage i
- `out_valid`  out  1  `out` updated this cycle
- `ovf`  out  N  sticky per-stage saturation flag

## Operation
- State `x[i]`, signed STATE_W.
- Decision `s[i]` = 1 when `x[i] >= 0`, else 0.
- Feedback `f[i]` = −KAPPA when `s[i]` = 1, +KAPPA otherwise.
- Step, taken only when `u_valid`=1 and `clr`=0. All terms use pre-step values (forward Euler):
  - `x[0]` ← sat(`x[0]` + sext(`u`) + `f[0]`)
  - `x[i]` ← sat(`x[i]` + (`x[i-1]` >>> BETA_SH) + `f[i]`) for i ≥ 1
  - `out` ← `s` (decisions from the pre-step state)
  - `out_valid` ← 1
- Arithmetic is done at STATE_W+2 bits and then saturated to [−2^(STATE_W-1), 2^(STATE_W-1)−1]. Any saturation of stage i sets `ovf[i]`, which stays set until `clr` or reset.
- No step (`u_valid`=0): `x`, `out` and `ovf` hold; `out_valid` ← 0.
- `clr`=1: `x` ← 0, `out` ← 0, `ovf` ← 0, `out_valid` ← 0. `clr` overrides `u_valid` in the same cycle, and that sample is dropped.
- State machine: none beyond the step enable. The block is always ready, with no backpressure. The downstream filter must accept `out` on every `out_valid`.

## Timing
- Reset values: `x`=0, `out`=0, `out_valid`=0, `ovf`=0. Reset is asserted asynchronously and deasserted synchronously, so reset mid-run discards all state immediately.
- Latency: `u` sampled at edge k is reflected in `out` at edge k+1 (stage-0 path). The control vector at edge k depends only on state before edge k.
- `out_valid` is a one-cycle pulse per accepted sample. Back-to-back `u_valid` gives back-to-back pulses at full clock rate.
- Critical path: one adder (three operands) plus saturation per stage. Stages run in parallel, with no ripple through the chain within a cycle.

## Structure
- Shared package `cb_pkg`: `cb_state_t` (signed STATE_W), a saturation function, and `CB_KAPPA_DEFAULT`. Control-vector bit ordering is defined here (bit i = stage i) so the filter side uses the same definition.
- Sub-module `cbadc_integrator`: one stage with inputs prev-state/input term, enable and clear, and outputs state, decision and ovf. It is instantiated N times via generate; stage 0 takes sign-extended `u` instead of the shifted previous state.
- Top `cbadc_modulator` handles the step enable, `out`/`out_valid` registers and clear priority.

## Test plan
- Reset: hold `rst`=0 for 5 cycles, then release → `out`=000, `out_valid`=0, `ovf`=000, all `x`=0.
- Zero input, defaults: `u`=0 with `u_valid`=1 continuously → `out` sequence 111, 000, 001 on the first three `out_valid` pulses; `x[0]` alternates −32768, 0.
- Gaps: same as previous, but deassert `u_valid` for 3 cycles after step 1 → `out_valid`=0 and `out` holds 111 during the gap; the next step yields 000 (identical to the ungapped sequence).
- Saturation: `STATE_W`=18, `KAPPA`=0, `u`=32767 constant → `x[0]` = 32767·k for k ≤ 4; step 5 clamps `x[0]` to 131071 and sets `ovf[0]`=1, which stays 1 for the following 10 steps.
- Clear priority: mid-run, assert `clr` together with `u_valid` → next cycle `x`=0, `out`=000, `out_valid`=0, `ovf`=000; the following step outputs `out`=111.
- Closed loop: drive `out` into `Batch_top` (depth 192, N=3, OSR=1) with a full-scale/2 sine `u` → filter output matches `u`, delayed, with SNR ≥ 60 dB after settling; `ovf` stays 000.
